apb_mem_slave: RTL and testbench

APB_MEM_SLAVE -- requirements
Module: apb_mem_slave

---
 rtl/apb_mem_slave.sv | 91 +++++++++
 tb/tb_apb_mem_slave.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// apb_mem_slave: APB word-addressed memory slave, wait states enabled by APB_SLV_WAIT_EN
module apb_mem_slave #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic                    pclk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   paddr,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [DATA_WIDTH-1:0]   pwdata,
    input  logic [DATA_WIDTH/8-1:0] pstrb,
    output logic                    pready,
    output logic [DATA_WIDTH-1:0]   prdata,
    output logic                    pslverr
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int IW = $clog2(DEPTH) > 0 ? $clog2(DEPTH) : 1;
    localparam int CW = ADDR_WIDTH > 32 ? ADDR_WIDTH : 32;
`ifdef APB_SLV_WAIT_EN
    localparam bit WAIT_EN = 1'b1;
`else
    localparam bit WAIT_EN = 1'b0;
`endif
    localparam logic [3:0] WS = WAIT_EN ? 4'(WAIT_STATES) : 4'd0;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t                  state, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [3:0]              cnt, cnt_d;
    logic                    pready_d;
    logic                    in_range;
    logic                    done;
    logic [IW-1:0]           idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    assign in_range = CW'(addr_q) < CW'(DEPTH);
    assign idx      = addr_q[IW-1:0];
    assign done     = state == ACCESS && psel && penable && pready;
    assign pslverr  = state == ACCESS && pready && !in_range;
    assign prdata   = (state == ACCESS && in_range) ? mem[idx] : '0;

    always_comb begin
        state_d  = state;
        addr_d   = addr_q;
        write_d  = write_q;
        cnt_d    = cnt;
        pready_d = pready;
        if (state == IDLE) begin
            if (psel && !penable) begin
                state_d  = ACCESS;
                addr_d   = paddr;
                write_d  = pwrite;
                cnt_d    = WS;
                pready_d = WS == 4'd0;
            end
        end else if (!psel || done) begin
            state_d  = IDLE;
            cnt_d    = 4'd0;
            pready_d = 1'b0;
        end else if (cnt != 4'd0) begin
            cnt_d    = cnt - 4'd1;
            pready_d = cnt == 4'd1;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            cnt     <= 4'd0;
            pready  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= DATA_WIDTH'(i);
        end else begin
            state   <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            cnt     <= cnt_d;
            pready  <= pready_d;
            if (done && write_q && in_range)
                for (int b = 0; b < NB; b++)
                    if (pstrb[b]) mem[idx][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_apb_mem_slave.sv
// tb_apb_mem_slave: randomized and directed checks of apb_mem_slave against a word-array model
module tb_apb_mem_slave;
    localparam int DW = 32, AW = 32, DEPTH = 256;
`ifdef APB_SLV_WAIT_EN
    localparam int EXP_WAITS = 2;
`else
    localparam int EXP_WAITS = 0;
`endif

    logic          pclk = 1'b0, rst = 1'b1, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0] paddr = '0;
    logic [DW-1:0] pwdata = '0;
    logic [3:0]    pstrb = '0;
    logic          pready, pslverr;
    logic [DW-1:0] prdata;
    logic [DW-1:0] model [DEPTH];
    int            checks = 0, failures = 0;

    always #5 pclk = ~pclk;

    apb_mem_slave dut (
        .pclk(pclk), .rst(rst), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
        .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expd);
        checks++;
        assert (obs === expd) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expd);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < DEPTH; i++) model[i] = i;
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d, input logic [3:0] s);
        merge = old;
        for (int b = 0; b < 4; b++) if (s[b]) merge[8*b +: 8] = d[8*b +: 8];
    endfunction

    // Setup drives decoy data and the real address; access phase swaps them to prove latching/sampling.
    task automatic xfer(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d, input logic [3:0] s,
                        output logic [DW-1:0] rd, output logic err, output int cycles);
        logic          in_rng;
        logic [DW-1:0] expd;
        int            waits;
        bit            seen;
        in_rng = a < DEPTH;
        expd   = in_rng ? model[a[7:0]] : '0;
        waits  = 0;
        seen   = 0;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = ~d; pstrb = ~s;
        tick;
        cycles = 1;
        penable = 1'b1; paddr = a ^ 32'h1; pwrite = !w; pwdata = d; pstrb = s;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (pready === 1'b1) seen = 1;
            else begin
                check("pslverr_wait", 64'(pslverr), 64'd0);
                if (!w) check("prdata_wait", 64'(prdata), 64'(expd));
                waits++;
                tick;
                cycles++;
            end
        end
        if (!seen) check("pready_timeout", 64'(pready), 64'd1);
        rd  = prdata;
        err = pslverr;
        check("waits", 64'(waits), 64'(EXP_WAITS));
        check("pslverr", 64'(pslverr), 64'(!in_rng));
        if (!w) check("prdata", 64'(prdata), 64'(expd));
        tick;
        cycles++;
        check("pready_after", 64'(pready), 64'd0);
        check("prdata_idle", 64'(prdata), 64'd0);
        psel = 1'b0; penable = 1'b0;
        if (w && in_rng) model[a[7:0]] = merge(model[a[7:0]], d, s);
    endtask

    initial begin
        logic [DW-1:0] rd;
        logic          err;
        int            c1, c2;
        logic [AW-1:0] a;
        logic          w;
        model_reset();
        repeat (3) tick;
        check("rst_pready", 64'(pready), 64'd0);
        check("rst_prdata", 64'(prdata), 64'd0);
        check("rst_pslverr", 64'(pslverr), 64'd0);
        rst = 1'b0;
        tick;

        xfer(32'd5, 1'b0, '0, 4'h0, rd, err, c1);
        check("read5", 64'(rd), 64'h5);
        check("read5_err", 64'(err), 64'd0);

        xfer(32'd10, 1'b1, 32'hDEADBEEF, 4'b0101, rd, err, c1);
        xfer(32'd10, 1'b0, '0, 4'h0, rd, err, c1);
        check("strb_read10", 64'(rd), 64'h00AD00EF);

        xfer(32'd300, 1'b1, 32'h12345678, 4'hF, rd, err, c1);
        check("oob300_err", 64'(err), 64'd1);
        xfer(32'h8000_0005, 1'b1, 32'h55AA55AA, 4'hF, rd, err, c1);
        check("oob_high_err", 64'(err), 64'd1);
        xfer(32'd256, 1'b0, '0, 4'h0, rd, err, c1);
        check("oob256_rd", 64'(rd), 64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            xfer(AW'(i), 1'b0, '0, 4'h0, rd, err, c1);
            check("sweep", 64'(rd), 64'(merge(i, 32'hDEADBEEF, (i == 10) ? 4'b0101 : 4'b0000)));
        end

        psel = 1'b1; penable = 1'b0; paddr = 32'd3; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        tick;
        penable = 1'b1;
        if (EXP_WAITS > 0) tick;
        psel = 1'b0; penable = 1'b0;
        tick;
        check("abort_pready", 64'(pready), 64'd0);
        check("abort_prdata", 64'(prdata), 64'd0);
        check("abort_pslverr", 64'(pslverr), 64'd0);
        xfer(32'd3, 1'b0, '0, 4'h0, rd, err, c1);
        check("abort_read3", 64'(rd), 64'h3);

        psel = 1'b1; penable = 1'b0; paddr = 32'd7; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        tick;
        penable = 1'b1;
        rst = 1'b1;
        tick;
        check("midrst_pready", 64'(pready), 64'd0);
        check("midrst_prdata", 64'(prdata), 64'd0);
        check("midrst_pslverr", 64'(pslverr), 64'd0);
        psel = 1'b0; penable = 1'b0; rst = 1'b0;
        model_reset();
        tick;
        xfer(32'd7, 1'b0, '0, 4'h0, rd, err, c1);
        check("midrst_read7", 64'(rd), 64'h7);

        xfer(32'd1, 1'b1, 32'h11, 4'hF, rd, err, c1);
        xfer(32'd1, 1'b0, '0, 4'h0, rd, err, c2);
        check("b2b_wr_cycles", 64'(c1), 64'(EXP_WAITS + 2));
        check("b2b_rd_cycles", 64'(c2), 64'(EXP_WAITS + 2));
        check("b2b_read1", 64'(rd), 64'h11);

        repeat (300) begin
            a = AW'($urandom_range(0, 299));
            w = 1'($urandom_range(0, 1));
            xfer(a, w, DW'($urandom), 4'($urandom_range(0, 15)), rd, err, c1);
            if ($urandom_range(0, 3) == 0) tick;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
